// File: rtl/seq_pkg.sv
// Shared types for the step sequencer: play modes and ping-pong direction.
package seq_pkg;

    typedef enum logic [1:0] {
        MODE_FWD      = 2'd0,
        MODE_REV      = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_ONESHOT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/seq_step_next.sv
// Combinational next-step rule: given the current step/direction, mode and
// normalised loop bounds, computes where one advance lands and what it signals.
module seq_step_next
    import seq_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic [STEP_W-1:0] step,
    input  dir_e              dir,
    input  mode_e             mode,
    input  logic [STEP_W-1:0] lo,
    input  logic [STEP_W-1:0] hi,
    output logic [STEP_W-1:0] next_step,
    output dir_e              next_dir,
    output logic              wrap_hit,
    output logic              oneshot_end
);

    always_comb begin
        next_step   = step;
        next_dir    = DIR_UP;
        wrap_hit    = 1'b0;
        oneshot_end = 1'b0;
        // A step left outside the region (bounds moved, or fresh from reset) snaps to origin
        if (step < lo || step > hi) begin
            next_step = (mode == MODE_REV) ? hi : lo;
        end else begin
            case (mode)
                MODE_FWD: begin
                    if (step == hi) begin
                        next_step = lo;
                        wrap_hit  = 1'b1;
                    end else begin
                        next_step = step + 1'b1;
                    end
                end
                MODE_REV: begin
                    if (step == lo) begin
                        next_step = hi;
                        wrap_hit  = 1'b1;
                    end else begin
                        next_step = step - 1'b1;
                    end
                end
                MODE_PINGPONG: begin
                    next_dir = dir;
                    if (lo == hi) begin
                        wrap_hit = 1'b1;
                    end else if (dir == DIR_UP) begin
                        if (step == hi) begin
                            // Turn around without repeating hi; a one-wide bounce lands straight on lo
                            next_step = step - 1'b1;
                            next_dir  = DIR_DOWN;
                            wrap_hit  = ((step - 1'b1) == lo);
                        end else begin
                            next_step = step + 1'b1;
                        end
                    end else begin
                        if (step == lo) begin
                            next_step = step + 1'b1;
                            next_dir  = DIR_UP;
                        end else begin
                            next_step = step - 1'b1;
                            wrap_hit  = ((step - 1'b1) == lo);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (step == hi) begin
                        wrap_hit    = 1'b1;
                        oneshot_end = 1'b1;
                    end else begin
                        next_step = step + 1'b1;
                    end
                end
                default: begin
                    next_step = step;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_step_counter.sv
// Step/measure counter: advances the step index on qualified tempo pulses inside
// a programmable loop region and counts completed loops as measures.
module seq_step_counter
    import seq_pkg::*;
#(
    parameter  int STEPS     = 16,
    parameter  int MEASURE_W = 4,
    localparam int STEP_W    = $clog2(STEPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    input  logic                 beat_pulse,
    input  logic                 restart,
    input  logic [1:0]           mode,
    input  logic [STEP_W-1:0]    loop_start,
    input  logic [STEP_W-1:0]    loop_end,
    output logic [STEP_W-1:0]    step,
    output logic                 step_pulse,
    output logic                 wrap,
    output logic [MEASURE_W-1:0] measure,
    output logic                 done
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    mode_e             mode_sel;
    dir_e              dir;
    dir_e              next_dir;
    logic [STEP_W-1:0] lo_raw;
    logic [STEP_W-1:0] hi_raw;
    logic [STEP_W-1:0] lo;
    logic [STEP_W-1:0] hi;
    logic [STEP_W-1:0] origin;
    logic [STEP_W-1:0] next_step;
    logic              wrap_hit;
    logic              oneshot_end;
    logic              advance;

    assign mode_sel = mode_e'(mode);
    assign advance  = beat_pulse & play;

    // Bounds may arrive in either order and, for non-power-of-two STEPS, beyond the last step
    always_comb begin
        lo_raw = (loop_start < loop_end) ? loop_start : loop_end;
        hi_raw = (loop_start < loop_end) ? loop_end : loop_start;
        lo     = (lo_raw > LAST) ? LAST : lo_raw;
        hi     = (hi_raw > LAST) ? LAST : hi_raw;
        origin = (mode_sel == MODE_REV) ? hi : lo;
    end

    seq_step_next #(
        .STEP_W(STEP_W)
    ) u_next (
        .step        (step),
        .dir         (dir),
        .mode        (mode_sel),
        .lo          (lo),
        .hi          (hi),
        .next_step   (next_step),
        .next_dir    (next_dir),
        .wrap_hit    (wrap_hit),
        .oneshot_end (oneshot_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step       <= '0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            measure    <= '0;
            done       <= 1'b0;
            dir        <= DIR_UP;
        end else begin
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            if (mode_sel != MODE_PINGPONG) dir <= DIR_UP;
            if (mode_sel != MODE_ONESHOT) done <= 1'b0;
            // Restart outranks a coincident advance
            if (restart) begin
                step       <= origin;
                dir        <= DIR_UP;
                done       <= 1'b0;
                measure    <= '0;
                step_pulse <= 1'b1;
            end else if (advance && !(done && mode_sel == MODE_ONESHOT)) begin
                step       <= next_step;
                step_pulse <= 1'b1;
                wrap       <= wrap_hit;
                if (wrap_hit) measure <= measure + 1'b1;
                if (mode_sel == MODE_PINGPONG) dir <= next_dir;
                if (oneshot_end) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_step_counter.sv
// Bench for seq_step_counter: directed scenarios plus random traffic, all checked
// cycle by cycle against an integer reference model of the sequencing rules.
module tb_seq_step_counter;

    localparam int STEPS     = 16;
    localparam int MEASURE_W = 2;
    localparam int STEP_W    = $clog2(STEPS);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 play = 1'b0;
    logic                 beat_pulse = 1'b0;
    logic                 restart = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic [STEP_W-1:0]    loop_start = '0;
    logic [STEP_W-1:0]    loop_end = '0;
    logic [STEP_W-1:0]    step;
    logic                 step_pulse;
    logic                 wrap;
    logic [MEASURE_W-1:0] measure;
    logic                 done;

    int tests = 0;
    int failed = 0;

    int m_step, m_meas;
    bit m_up, m_done, m_pulse, m_wrap, skip_pulse;

    seq_step_counter #(
        .STEPS     (STEPS),
        .MEASURE_W (MEASURE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .beat_pulse (beat_pulse),
        .restart    (restart),
        .mode       (mode),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .step       (step),
        .step_pulse (step_pulse),
        .wrap       (wrap),
        .measure    (measure),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_step = 0; m_meas = 0; m_up = 1'b1; m_done = 1'b0;
        m_pulse = 1'b0; m_wrap = 1'b0; skip_pulse = 1'b0;
    endtask

    // One clock of the sequencer written as integer arithmetic on the loop region
    task automatic model_clock();
        int a, b, lo, hi, org, nx, md;
        bit adv;
        a  = int'(loop_start);
        b  = int'(loop_end);
        md = int'(mode);
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (hi > STEPS - 1) hi = STEPS - 1;
        if (lo > STEPS - 1) lo = STEPS - 1;
        org = (md == 1) ? hi : lo;
        m_pulse = 1'b0; m_wrap = 1'b0; skip_pulse = 1'b0;
        adv = beat_pulse && play;
        if (md != 2) m_up = 1'b1;
        if (md != 3) m_done = 1'b0;
        if (restart) begin
            m_step = org; m_up = 1'b1; m_done = 1'b0; m_meas = 0; m_pulse = 1'b1;
        end else if (adv && !(m_done && md == 3)) begin
            m_pulse = 1'b1;
            if (m_step < lo || m_step > hi) begin
                m_step = org; m_up = 1'b1;
            end else begin
                case (md)
                    0: if (m_step == hi) begin m_step = lo; m_wrap = 1'b1; end else m_step = m_step + 1;
                    1: if (m_step == lo) begin m_step = hi; m_wrap = 1'b1; end else m_step = m_step - 1;
                    2: begin
                        if (lo == hi) m_wrap = 1'b1;
                        else begin
                            nx = m_step + (m_up ? 1 : -1);
                            if (nx > hi) begin m_up = 1'b0; nx = m_step - 1; end
                            else if (nx < lo) begin m_up = 1'b1; nx = m_step + 1; end
                            m_wrap = (nx < m_step) && (nx == lo);
                            m_step = nx;
                        end
                    end
                    default: if (m_step == hi) begin m_done = 1'b1; m_wrap = 1'b1; skip_pulse = 1'b1; end
                             else m_step = m_step + 1;
                endcase
            end
            if (m_wrap) m_meas = (m_meas + 1) % (1 << MEASURE_W);
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
        check("step", 32'(step), 32'(m_step));
        if (!skip_pulse) check("step_pulse", 32'(step_pulse), 32'(m_pulse));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("measure", 32'(measure), 32'(m_meas));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic beats(input int n);
        beat_pulse = 1'b1;
        for (int i = 0; i < n; i++) tick();
        beat_pulse = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_step", 32'(step), 32'd0);
        check("reset_pulse", 32'(step_pulse), 32'd0);
        check("reset_measure", 32'(measure), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Forward full loop: 1..15,0,1
        play = 1'b1; mode = 2'd0; loop_start = 4'd0; loop_end = 4'd15;
        beats(17);
        check("fwd_final_step", 32'(step), 32'd1);
        check("fwd_measure", 32'(measure), 32'd1);

        // Reverse with swapped bounds: 12, 11..4, 12
        mode = 2'd1; loop_start = 4'd12; loop_end = 4'd4;
        beats(10);
        check("rev_final_step", 32'(step), 32'd12);
        check("rev_wrap", 32'(wrap), 32'd1);

        // Ping-pong 2..5 then degenerate 7..7
        mode = 2'd2; loop_start = 4'd2; loop_end = 4'd5;
        do_restart();
        beats(7);
        check("pp_final_step", 32'(step), 32'd3);
        check("pp_measure", 32'(measure), 32'd1);
        loop_start = 4'd7; loop_end = 4'd7;
        beats(3);
        check("pp_single_step", 32'(step), 32'd7);

        // One-shot 0..3, beats after the end are ignored
        mode = 2'd3; loop_start = 4'd0; loop_end = 4'd3;
        do_restart();
        beats(7);
        check("os_done", 32'(done), 32'd1);
        check("os_hold_step", 32'(step), 32'd3);
        do_restart();
        check("os_restart_pulse", 32'(step_pulse), 32'd1);
        check("os_restart_done", 32'(done), 32'd0);

        // Restart coinciding with a beat mid-loop
        mode = 2'd0; loop_start = 4'd0; loop_end = 4'd15;
        beats(5);
        beat_pulse = 1'b1; restart = 1'b1;
        tick();
        beat_pulse = 1'b0; restart = 1'b0;
        check("rst_beat_step", 32'(step), 32'd0);
        check("rst_beat_wrap", 32'(wrap), 32'd0);

        // Paused: beats have no effect
        beats(3);
        play = 1'b0;
        beats(4);
        check("pause_step", 32'(step), 32'd3);
        check("pause_pulse", 32'(step_pulse), 32'd0);
        play = 1'b1;

        // Five loops of a two-step region roll the 2-bit measure 3->0->1
        loop_start = 4'd0; loop_end = 4'd1;
        do_restart();
        beats(10);
        check("measure_rollover", 32'(measure), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) begin
                mode       = 2'($urandom_range(0, 3));
                loop_start = 4'($urandom_range(0, 15));
                loop_end   = 4'($urandom_range(0, 15));
            end
            beat_pulse = 1'($urandom_range(0, 1));
            play       = ($urandom_range(0, 7) != 0);
            restart    = ($urandom_range(0, 31) == 0);
            tick();
        end
        restart = 1'b0;

        // Asynchronous reset mid-run, then normalisation on the first advance
        play = 1'b1; mode = 2'd0; loop_start = 4'd0; loop_end = 4'd15;
        do_restart();
        beats(6);
        beat_pulse = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_step", 32'(step), 32'd0);
        check("arst_pulse", 32'(step_pulse), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        check("arst_measure", 32'(measure), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        beat_pulse = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        mode = 2'd1; loop_start = 4'd12; loop_end = 4'd4;
        beats(2);
        check("post_reset_step", 32'(step), 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
